// File: rtl/ram_wb_wr_arb.sv
// Write-port arbiter for the writeback RAM: round-robin between the CPU writeback
// stage (req0) and a loader/debug master (req1) that may lock the port for bursts.
module ram_wb_wr_arb #(
    parameter int         MAX_BURST = 8,
    parameter int         RAM_WORDS = 8,
    parameter logic [7:0] IO_ADDR   = 8'h40
) (
    input  logic        CLK_WB,
    input  logic        RST_N,
    input  logic        REQ0_VALID,
    input  logic [7:0]  REQ0_ADDR,
    input  logic [15:0] REQ0_DATA,
    output logic        REQ0_READY,
    input  logic        REQ1_VALID,
    input  logic [7:0]  REQ1_ADDR,
    input  logic [15:0] REQ1_DATA,
    input  logic        REQ1_LOCK,
    output logic        REQ1_READY,
    output logic [7:0]  RAM_ADDR,
    output logic [15:0] RAM_IN,
    output logic        RAM_WEN,
    output logic        ADDR_ERR,
    input  logic        ERR_CLR
);

    localparam int               CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [8:0]       RAM_LIM  = 9'(RAM_WORDS);
    // With MAX_BURST=1 a lock can never outlast its own grant cycle.
    localparam bit               LOCK_EN  = (MAX_BURST > 1);

    typedef enum logic {ARB, LOCK1} state_t;

    state_t            state_q;
    logic              last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        ram_addr_q, ram_addr_d;
    logic [15:0]       ram_in_q, ram_in_d;
    logic              ram_wen_q, ram_wen_d;
    logic              addr_err_q, addr_err_d;

    logic        gnt0, gnt1, acc, legal;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == ARB) begin
            if (REQ0_VALID && REQ1_VALID) begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end else begin
                gnt0 = REQ0_VALID;
                gnt1 = REQ1_VALID;
            end
        end else begin
            gnt1 = REQ1_VALID;
        end
    end

    assign REQ0_READY = gnt0;
    assign REQ1_READY = gnt1;
    assign acc        = gnt0 | gnt1;
    assign wr_addr    = gnt1 ? REQ1_ADDR : REQ0_ADDR;
    assign wr_data    = gnt1 ? REQ1_DATA : REQ0_DATA;
    assign legal      = ({1'b0, wr_addr} < RAM_LIM) || (wr_addr == IO_ADDR);

    // Illegal writes still consume the handshake but never reach the RAM.
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_in_d   = ram_in_q;
        ram_wen_d  = 1'b0;
        addr_err_d = addr_err_q;
        if (acc && legal) begin
            ram_addr_d = wr_addr;
            ram_in_d   = wr_data;
            ram_wen_d  = 1'b1;
        end
        if (acc && !legal) begin
            addr_err_d = 1'b1;
        end else if (ERR_CLR) begin
            addr_err_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_WB or negedge RST_N) begin
        if (!RST_N) begin
            ram_addr_q <= '0;
            ram_in_q   <= '0;
            ram_wen_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            ram_addr_q <= ram_addr_d;
            ram_in_q   <= ram_in_d;
            ram_wen_q  <= ram_wen_d;
            addr_err_q <= addr_err_d;
        end
    end

    // CNT counts port-hold cycles including the grant that took the lock, so
    // a burst never exceeds MAX_BURST transfers.
    always_ff @(posedge CLK_WB or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ARB;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    cnt_q <= '0;
                    if (gnt0) last_q <= 1'b0;
                    if (gnt1) begin
                        last_q <= 1'b1;
                        if (REQ1_LOCK && LOCK_EN) begin
                            state_q <= LOCK1;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                LOCK1: begin
                    last_q <= 1'b1;
                    if (!REQ1_LOCK || cnt_q == CNT_LAST) begin
                        state_q <= ARB;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ARB;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign RAM_ADDR = ram_addr_q;
    assign RAM_IN   = ram_in_q;
    assign RAM_WEN  = ram_wen_q;
    assign ADDR_ERR = addr_err_q;

endmodule

// File: tb/tb_ram_wb_wr_arb.sv
// Directed bench for ram_wb_wr_arb: reset, round robin, lock bursts, address filter.
module tb_ram_wb_wr_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v1, lock1, err_clr;
    logic [7:0]  a0, a1;
    logic [15:0] d0, d1;
    logic        r0, r1, wen, aerr;
    logic [7:0]  raddr;
    logic [15:0] rin;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0]  exp_addr;
    logic [15:0] exp_data;

    ram_wb_wr_arb #(.MAX_BURST(8), .RAM_WORDS(8), .IO_ADDR(8'h40)) dut (
        .CLK_WB(clk), .RST_N(rst_n),
        .REQ0_VALID(v0), .REQ0_ADDR(a0), .REQ0_DATA(d0), .REQ0_READY(r0),
        .REQ1_VALID(v1), .REQ1_ADDR(a1), .REQ1_DATA(d1), .REQ1_LOCK(lock1), .REQ1_READY(r1),
        .RAM_ADDR(raddr), .RAM_IN(rin), .RAM_WEN(wen), .ADDR_ERR(aerr), .ERR_CLR(err_clr)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        v0 = 0; v1 = 0; lock1 = 0; err_clr = 0;
        a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #3;
        n_chk++; if (wen !== 1'b0 || raddr !== 8'h00 || rin !== 16'h0000 || aerr !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: wen=%b addr=%h in=%h err=%b, want 0/00/0000/0", wen, raddr, rin, aerr); end
        n_chk++; if (r0 !== 1'b0 || r1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready_idle: r0=%b r1=%b, want 0 0", r0, r1); end
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_write();
        v0 = 1; a0 = 8'd3; d0 = 16'h1234;
        @(negedge clk);
        n_chk++; if (r0 !== 1'b1 || r1 !== 1'b0) begin
            n_fail++; $display("FAIL t1_ready: r0=%b r1=%b, want 1 0", r0, r1); end
        @(posedge clk); #1 v0 = 0;
        n_chk++; if (wen !== 1'b1 || raddr !== 8'd3 || rin !== 16'h1234) begin
            n_fail++; $display("FAIL t1_write: wen=%b addr=%h in=%h, want 1/03/1234", wen, raddr, rin); end
        @(posedge clk); #1;
        n_chk++; if (wen !== 1'b0 || raddr !== 8'd3 || rin !== 16'h1234) begin
            n_fail++; $display("FAIL t1_hold: wen=%b addr=%h in=%h, want 0/03/1234", wen, raddr, rin); end
    endtask

    task automatic test_round_robin();
        idle_inputs();
        rst_n = 0; #2 rst_n = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            v0 = 1; a0 = 8'(i);     d0 = 16'h0A00 + 16'(i);
            v1 = 1; a1 = 8'(7 - i); d1 = 16'h0B00 + 16'(i);
            if (i % 2 == 0) begin exp_addr = 8'(i); exp_data = 16'h0A00 + 16'(i); end
            else            begin exp_addr = 8'(7 - i); exp_data = 16'h0B00 + 16'(i); end
            @(negedge clk);
            n_chk++; if (r0 !== (i % 2 == 0) || r1 !== (i % 2 == 1)) begin
                n_fail++; $display("FAIL t2_grant[%0d]: r0=%b r1=%b, want %b %b", i, r0, r1, i % 2 == 0, i % 2 == 1); end
            @(posedge clk); #1;
            n_chk++; if (wen !== 1'b1 || raddr !== exp_addr || rin !== exp_data) begin
                n_fail++; $display("FAIL t2_write[%0d]: wen=%b addr=%h in=%h, want 1/%h/%h", i, wen, raddr, rin, exp_addr, exp_data); end
        end
        idle_inputs();
        @(posedge clk); #1;
        n_chk++; if (wen !== 1'b0) begin
            n_fail++; $display("FAIL t2_idle: wen=%b, want 0", wen); end
    endtask

    task automatic test_lock_burst();
        int j;
        logic g1;
        // one req0 write so that req1 owns the next contest
        v0 = 1; a0 = 8'd6; d0 = 16'hD00D;
        @(posedge clk); #1;
        n_chk++; if (wen !== 1'b1 || raddr !== 8'd6 || rin !== 16'hD00D) begin
            n_fail++; $display("FAIL t3_pre: wen=%b addr=%h in=%h, want 1/06/d00d", wen, raddr, rin); end
        j = 0;
        for (int k = 0; k < 13; k++) begin
            g1 = (k != 8);
            v0 = 1; a0 = 8'd6;       d0 = 16'hD000 + 16'(k);
            v1 = 1; a1 = 8'(j % 8);  d1 = 16'hC000 + 16'(j); lock1 = 1;
            exp_addr = g1 ? 8'(j % 8) : 8'd6;
            exp_data = g1 ? 16'hC000 + 16'(j) : 16'hD000 + 16'(k);
            @(negedge clk);
            n_chk++; if (r1 !== g1 || r0 !== !g1) begin
                n_fail++; $display("FAIL t3_grant[%0d]: r0=%b r1=%b, want %b %b", k, r0, r1, !g1, g1); end
            @(posedge clk); #1;
            n_chk++; if (wen !== 1'b1 || raddr !== exp_addr || rin !== exp_data) begin
                n_fail++; $display("FAIL t3_write[%0d]: wen=%b addr=%h in=%h, want 1/%h/%h", k, wen, raddr, rin, exp_addr, exp_data); end
            if (g1) j++;
        end
        idle_inputs();
        @(negedge clk);
        n_chk++; if (r0 !== 1'b0 || r1 !== 1'b0) begin
            n_fail++; $display("FAIL t3_release: r0=%b r1=%b, want 0 0", r0, r1); end
        @(posedge clk); #1;
        n_chk++; if (wen !== 1'b0 || raddr !== exp_addr) begin
            n_fail++; $display("FAIL t3_end: wen=%b addr=%h, want 0/%h", wen, raddr, exp_addr); end
    endtask

    task automatic test_addr_filter();
        v1 = 1; a1 = 8'h08; d1 = 16'h1111;
        @(negedge clk);
        n_chk++; if (r1 !== 1'b1) begin
            n_fail++; $display("FAIL t4_illegal_ready: r1=%b, want 1", r1); end
        @(posedge clk); #1;
        n_chk++; if (wen !== 1'b0 || raddr !== exp_addr || rin !== exp_data || aerr !== 1'b1) begin
            n_fail++; $display("FAIL t4_illegal: wen=%b addr=%h in=%h err=%b, want 0/%h/%h/1", wen, raddr, rin, aerr, exp_addr, exp_data); end
        a1 = 8'h40; d1 = 16'hBEEF;
        @(posedge clk); #1;
        n_chk++; if (wen !== 1'b1 || raddr !== 8'h40 || rin !== 16'hBEEF || aerr !== 1'b1) begin
            n_fail++; $display("FAIL t4_io64: wen=%b addr=%h in=%h err=%b, want 1/40/beef/1", wen, raddr, rin, aerr); end
        v1 = 0; err_clr = 1;
        @(posedge clk); #1;
        n_chk++; if (aerr !== 1'b0 || wen !== 1'b0) begin
            n_fail++; $display("FAIL t4_clear: err=%b wen=%b, want 0 0", aerr, wen); end
        err_clr = 0; v0 = 1; a0 = 8'h07; d0 = 16'h7777;
        @(posedge clk); #1;
        n_chk++; if (wen !== 1'b1 || raddr !== 8'h07 || rin !== 16'h7777 || aerr !== 1'b0) begin
            n_fail++; $display("FAIL t4_addr7: wen=%b addr=%h in=%h err=%b, want 1/07/7777/0", wen, raddr, rin, aerr); end
        a0 = 8'hFF; d0 = 16'hFFFF;
        @(posedge clk); #1;
        n_chk++; if (wen !== 1'b0 || raddr !== 8'h07 || aerr !== 1'b1) begin
            n_fail++; $display("FAIL t4_addrff: wen=%b addr=%h err=%b, want 0/07/1", wen, raddr, aerr); end
        a0 = 8'h41; d0 = 16'h4141; err_clr = 1;
        @(posedge clk); #1;
        n_chk++; if (wen !== 1'b0 || rin !== 16'h7777 || aerr !== 1'b1) begin
            n_fail++; $display("FAIL t4_clr_vs_err: wen=%b in=%h err=%b, want 0/7777/1", wen, rin, aerr); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        for (int c = 0; c < 4; c++) begin
            v1 = 1; lock1 = 1; a1 = 8'(c); d1 = 16'h5A00 + 16'(c);
            @(posedge clk); #1;
            n_chk++; if (wen !== 1'b1 || raddr !== 8'(c)) begin
                n_fail++; $display("FAIL t5_burst[%0d]: wen=%b addr=%h, want 1/%h", c, wen, raddr, 8'(c)); end
        end
        rst_n = 0;
        #1;
        n_chk++; if (wen !== 1'b0 || raddr !== 8'h00 || rin !== 16'h0000 || aerr !== 1'b0) begin
            n_fail++; $display("FAIL t5_async_reset: wen=%b addr=%h in=%h err=%b, want 0/00/0000/0", wen, raddr, rin, aerr); end
        @(posedge clk); #1 rst_n = 1;
        v0 = 1; a0 = 8'd1; d0 = 16'h0101;
        v1 = 1; a1 = 8'd2; d1 = 16'h0202; lock1 = 0;
        @(negedge clk);
        n_chk++; if (r0 !== 1'b1 || r1 !== 1'b0) begin
            n_fail++; $display("FAIL t5_first_contest: r0=%b r1=%b, want 1 0", r0, r1); end
        @(posedge clk); #1;
        n_chk++; if (wen !== 1'b1 || raddr !== 8'd1 || rin !== 16'h0101) begin
            n_fail++; $display("FAIL t5_write: wen=%b addr=%h in=%h, want 1/01/0101", wen, raddr, rin); end
        idle_inputs();
    endtask

    task automatic test_lock_idle();
        v1 = 1; lock1 = 1; a1 = 8'd2; d1 = 16'h2222;
        @(negedge clk);
        n_chk++; if (r1 !== 1'b1) begin
            n_fail++; $display("FAIL t6_lock_grant: r1=%b, want 1", r1); end
        @(posedge clk); #1;
        v1 = 0; v0 = 1; a0 = 8'd5; d0 = 16'h5555;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            n_chk++; if (r0 !== 1'b0 || r1 !== 1'b0) begin
                n_fail++; $display("FAIL t6_blocked[%0d]: r0=%b r1=%b, want 0 0", c, r0, r1); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_chk++; if (r0 !== 1'b1) begin
            n_fail++; $display("FAIL t6_req0_after: r0=%b, want 1", r0); end
        @(posedge clk); #1;
        n_chk++; if (wen !== 1'b1 || raddr !== 8'd5 || rin !== 16'h5555) begin
            n_fail++; $display("FAIL t6_write: wen=%b addr=%h in=%h, want 1/05/5555", wen, raddr, rin); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_lock_burst();
        test_addr_filter();
        test_reset_mid_burst();
        test_lock_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
